// File: rtl/nios2_into_scanner.sv
// nios2_into_scanner: Avalon-MM slave that feeds CPU-written bytes to the scanner.
// Optional IRQ feature: define NIOS2_INTO_SCANNER_IRQ_EN.
module nios2_into_scanner #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
`ifdef NIOS2_INTO_SCANNER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          en_q, en_d;
    logic [7:0]    last_q, last_d;
    logic [31:0]   readdata_q, readdata_d;

    logic wr;
    logic wr_data;
    logic wr_stat;
    logic wr_ctrl;
    logic flush;
    logic pop;
    logic push_ok;
    logic push_drop;
    logic empty;
    logic full;
    logic [31:0] status;
    logic [31:0] control;

`ifdef NIOS2_INTO_SCANNER_IRQ_EN
    logic irq_mask_q, irq_mask_d;
    logic irq_q, irq_d;
`endif

    logic [23:0] unused_wdata;
    assign unused_wdata = writedata[31:8];

    assign wr      = chipselect & ~write_n;
    assign wr_data = wr & (address == 2'd0);
    assign wr_stat = wr & (address == 2'd1);
    assign wr_ctrl = wr & (address == 2'd2);
    assign flush   = wr_ctrl & writedata[1];

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign out_valid = en_q & ~empty;
    assign out_data  = empty ? 8'h00 : mem[rd_ptr_q];
    assign pop       = out_valid & out_ready;

    // A full FIFO can still take a byte when the head leaves in the same cycle.
    assign push_ok   = wr_data & ~flush & (~full | pop);
    assign push_drop = wr_data & ~flush & full & ~pop;

    assign readdata = readdata_q;

    // Status and control word assembly for the read mux.
    always_comb begin
        status           = '0;
        status[0]        = empty;
        status[1]        = full;
        status[2]        = ovf_q;
        status[8+AW:8]   = count_q;
        control          = '0;
        control[0]       = en_q;
`ifdef NIOS2_INTO_SCANNER_IRQ_EN
        status[3]        = irq_q;
        control[2]       = irq_mask_q;
`endif
    end

    // Next-state for pointers, count, flags and read data.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        en_d       = en_q;
        last_d     = last_q;
        readdata_d = '0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok & ~pop)      count_d = count_q + 1'b1;
            else if (pop & ~push_ok) count_d = count_q - 1'b1;
        end

        if (push_ok) last_d = writedata[7:0];

        if (push_drop)
            ovf_d = 1'b1;
        else if (wr_stat & writedata[2])
            ovf_d = 1'b0;

        if (wr_ctrl) en_d = writedata[0];

        case (address)
            2'd0:    readdata_d = {24'h0, last_q};
            2'd1:    readdata_d = status;
            2'd2:    readdata_d = control;
            default: readdata_d = '0;
        endcase
    end

`ifdef NIOS2_INTO_SCANNER_IRQ_EN
    // Interrupt mask write and registered drain interrupt.
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_ctrl) irq_mask_d = writedata[2];
        irq_d = irq_mask_q & empty & ~flush;
    end

    // Interrupt state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    // Control and pointer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            en_q       <= 1'b0;
            last_q     <= '0;
            readdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            en_q       <= en_d;
            last_q     <= last_d;
            readdata_q <= readdata_d;
        end
    end

    // Byte storage; contents are qualified by count so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= writedata[7:0];
    end

endmodule

// File: tb/tb_nios2_into_scanner.sv
// tb_nios2_into_scanner: directed checks of the Nios II to scanner byte FIFO.
// Optional IRQ checks are compiled when NIOS2_INTO_SCANNER_IRQ_EN is defined.
module tb_nios2_into_scanner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef NIOS2_INTO_SCANNER_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios2_into_scanner #(.DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef NIOS2_INTO_SCANNER_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    initial begin
        // 1: reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_data", {24'b0, out_data}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd1);
        chk("status_after_reset", readdata, 32'h0000_0001);

        // 2: basic push and stream
        wr(2'd2, 32'h1);
        chk("valid_before_push", {31'b0, out_valid}, 32'h0);
        wr(2'd0, 32'hFFFF_FFA5);
        chk("valid_after_push", {31'b0, out_valid}, 32'h1);
        chk("head_a5", {24'b0, out_data}, 32'hA5);
        wr(2'd0, 32'h3C);
        rd(2'd1);
        chk("status_cnt2", readdata, 32'h0000_0200);
        chk("head_stable", {24'b0, out_data}, 32'hA5);
        out_ready = 1'b1;
        chk("pop1_data", {24'b0, out_data}, 32'hA5);
        tick();
        chk("pop2_data", {24'b0, out_data}, 32'h3C);
        chk("pop2_valid", {31'b0, out_valid}, 32'h1);
        tick();
        chk("drained_valid", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b0;

        // 3: overflow with stream disabled
        wr(2'd2, 32'h0);
        for (int i = 1; i <= 9; i++) wr(2'd0, i);
        rd(2'd1);
        chk("status_full_ovf", readdata, 32'h0000_0806);
        chk("valid_disabled", {31'b0, out_valid}, 32'h0);
        wr(2'd2, 32'h1);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("stream_%0d", i), {23'b0, out_valid, out_data},
                32'h100 | i);
            tick();
        end
        chk("no_byte9", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b0;
        rd(2'd1);
        chk("ovf_still_set", readdata, 32'h0000_0005);
        wr(2'd1, 32'h4);
        rd(2'd1);
        chk("ovf_cleared", readdata, 32'h0000_0001);

        // 4: push into full FIFO while popping
        for (int i = 0; i < 8; i++) wr(2'd0, 32'h11 + i);
        rd(2'd1);
        chk("full_no_ovf", readdata, 32'h0000_0802);
        out_ready = 1'b1;
        wr(2'd0, 32'h77);
        out_ready = 1'b0;
        rd(2'd1);
        chk("full_push_pop", readdata, 32'h0000_0802);
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("drain_%0d", i), {23'b0, out_valid, out_data},
                32'h112 + i);
            tick();
        end
        chk("last_77", {23'b0, out_valid, out_data}, 32'h177);
        tick();
        chk("drain_done", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b0;

        // 5: flush keeps overflow and enable
        for (int i = 0; i < 3; i++) wr(2'd0, 32'hB1 + i);
        wr(2'd2, 32'h3);
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        rd(2'd1);
        chk("flush_status", readdata, 32'h0000_0001);
        rd(2'd2);
        chk("ctrl_after_flush", readdata, 32'h0000_0001);
        wr(2'd2, 32'h0);
        for (int i = 0; i < 9; i++) wr(2'd0, 32'hC1 + i);
        rd(2'd0);
        chk("data_last_pushed", readdata, 32'h0000_00C8);
        wr(2'd2, 32'h3);
        rd(2'd1);
        chk("flush_keeps_ovf", readdata, 32'h0000_0005);
        wr(2'd1, 32'h4);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3);
        chk("addr3_zero", readdata, 32'h0);

        // 6: async reset mid-stream
        wr(2'd0, 32'h5A);
        wr(2'd0, 32'h6B);
        rd(2'd1);
        chk("pre_reset_status", readdata, 32'h0000_0200);
        chk("pre_reset_valid", {31'b0, out_valid}, 32'h1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, out_valid}, 32'h0);
        chk("async_readdata", readdata, 32'h0);
        chk("async_data", {24'b0, out_data}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd1);
        chk("post_reset_status", readdata, 32'h0000_0001);

`ifdef NIOS2_INTO_SCANNER_IRQ_EN
        chk("irq_reset", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h5);
        wr(2'd0, 32'h42);
        tick();
        chk("irq_busy", {31'b0, irq}, 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("irq_drained", {31'b0, irq}, 32'h1);
        rd(2'd1);
        chk("irq_status", readdata, 32'h0000_0009);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
